oc8051_ecall_unit: RTL and testbench

Sequencer that consumes the Ecall Target Register value and performs the secure-call entry/return transfer for the 8051 core. On an ECALL from the decoder it saves the return PC on a private hardware return stack, redirects fetch to the ETR target and raises secure mode; on ERET it pops the stack and restores the PC. Sits between the SFR block (ETR source), the instruction decoder (request source) and the PC/fetch logic (redirect sink).

---
 rtl/oc8051_ecall_unit_pkg.sv | 26 ++
 rtl/oc8051_ecall_unit_ret_stack.sv | 59 +++++
 rtl/oc8051_ecall_unit.sv | 172 +++++++++++++++++
 tb/tb_oc8051_ecall_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_ecall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oc8051_ecall_unit_pkg
// Description : Shared fault codes and sequencer state encoding for the
//               secure-call (ECALL/ERET) unit of the 8051 core.
// Revision    : 1.0 - initial release
// ============================================================================
package oc8051_ecall_unit_pkg;

   // Sticky fault codes reported on fault_code
   localparam logic [1:0] OC8051_ECALL_F_NONE = 2'b00;
   localparam logic [1:0] OC8051_ECALL_F_OVF  = 2'b01;
   localparam logic [1:0] OC8051_ECALL_F_UNF  = 2'b10;
   localparam logic [1:0] OC8051_ECALL_F_ILL  = 2'b11;

   // Entry/return sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_E_PUSH = 3'd1,
      ST_E_JUMP = 3'd2,
      ST_R_POP  = 3'd3,
      ST_R_JUMP = 3'd4
   } ecall_state_t;

endpackage : oc8051_ecall_unit_pkg
`default_nettype wire

// File: rtl/oc8051_ecall_unit_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : oc8051_ret_stack
// Description : DEPTH x 16 private hardware return stack (LIFO). Entries are
//               never cleared; only the occupancy pointer moves. The top entry
//               is presented combinationally on pop_data.
// Revision    : 1.0 - initial release
// ============================================================================
module oc8051_ret_stack #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [15:0]                push_data,
   output logic [15:0]                pop_data,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       full,
   output logic                       empty
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_DW = c_AW + 1;

   logic [15:0]     r_mem [DEPTH];
   logic [c_DW-1:0] r_depth;
   logic [c_AW-1:0] w_wr_idx;
   logic [c_AW-1:0] w_rd_idx;

   // Write slot is the current occupancy; top entry sits one below it
   assign w_wr_idx = r_depth[c_AW-1:0];
   assign w_rd_idx = w_wr_idx - c_AW'(1);

   assign full     = (r_depth == c_DW'(DEPTH));
   assign empty    = (r_depth == '0);
   assign depth    = r_depth;
   assign pop_data = r_mem[w_rd_idx];

   // Occupancy pointer: guarded so a stray push/pop can never wrap it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_depth <= '0;
      end else if (push && !full) begin
         r_depth <= r_depth + c_DW'(1);
      end else if (pop && !empty) begin
         r_depth <= r_depth - c_DW'(1);
      end
   end

   // Storage array: written on push only, contents survive pops and reset
   always_ff @(posedge clk) begin
      if (push && !full) begin
         r_mem[w_wr_idx] <= push_data;
      end
   end

endmodule : oc8051_ret_stack
`default_nettype wire

// File: rtl/oc8051_ecall_unit.sv
`default_nettype none
// ============================================================================
// Module      : oc8051_ecall_unit
// Description : Secure-call sequencer. ECALL pushes the return PC, redirects
//               fetch to the latched ETR target and raises secure mode; ERET
//               pops the return PC and restores it. Illegal requests raise a
//               sticky fault without touching stack, secure flag or PC.
// Revision    : 1.0 - initial release
// ============================================================================
module oc8051_ecall_unit
   import oc8051_ecall_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ecall_req,
   input  logic                       eret_req,
   input  logic [15:0]                pc,
   input  logic [15:0]                etr,
   input  logic                       fault_clr,
   output logic                       stall,
   output logic                       pc_wr,
   output logic [15:0]                pc_target,
   output logic                       secure,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       fault,
   output logic [1:0]                 fault_code
);

   ecall_state_t r_state;
   ecall_state_t w_state_nxt;

   logic        w_push;
   logic        w_pop;
   logic        w_accept_e;
   logic        w_fault_set;
   logic [1:0]  w_fault_code;

   logic [15:0] r_ret_pc;
   logic [15:0] r_target;
   logic        r_secure;
   logic        r_fault;
   logic [1:0]  r_fault_code;

   logic [15:0] w_stk_top;
   logic        w_stk_full;
   logic        w_stk_empty;

   oc8051_ret_stack #(
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (r_ret_pc),
      .pop_data  (w_stk_top),
      .depth     (depth),
      .full      (w_stk_full),
      .empty     (w_stk_empty)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, stack strobes and fault detection; requests only honoured in IDLE
   always_comb begin
      w_state_nxt  = r_state;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_accept_e   = 1'b0;
      w_fault_set  = 1'b0;
      w_fault_code = OC8051_ECALL_F_NONE;
      case (r_state)
         ST_IDLE: begin
            if (ecall_req && eret_req) begin
               w_fault_set  = 1'b1;
               w_fault_code = OC8051_ECALL_F_ILL;
            end else if (ecall_req) begin
               if (w_stk_full) begin
                  w_fault_set  = 1'b1;
                  w_fault_code = OC8051_ECALL_F_OVF;
               end else if (etr == 16'h0000) begin
                  w_fault_set  = 1'b1;
                  w_fault_code = OC8051_ECALL_F_ILL;
               end else begin
                  w_accept_e  = 1'b1;
                  w_state_nxt = ST_E_PUSH;
               end
            end else if (eret_req) begin
               if (w_stk_empty) begin
                  w_fault_set  = 1'b1;
                  w_fault_code = OC8051_ECALL_F_UNF;
               end else begin
                  w_state_nxt = ST_R_POP;
               end
            end
         end
         ST_E_PUSH: begin
            w_push      = 1'b1;
            w_state_nxt = ST_E_JUMP;
         end
         ST_E_JUMP: begin
            w_state_nxt = ST_IDLE;
         end
         ST_R_POP: begin
            w_pop       = 1'b1;
            w_state_nxt = ST_R_JUMP;
         end
         ST_R_JUMP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Return-PC / target latches and secure flag. ETR is captured at acceptance
   // so later ETR writes cannot redirect an in-flight entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ret_pc <= 16'h0000;
         r_target <= 16'h0000;
         r_secure <= 1'b0;
      end else begin
         if (w_accept_e) begin
            r_ret_pc <= pc;
            r_target <= etr;
         end
         if (w_pop) begin
            r_target <= w_stk_top;
         end
         if (r_state == ST_E_JUMP) begin
            r_secure <= 1'b1;
         end else if (r_state == ST_R_JUMP) begin
            // Depth already reflects the pop; stay secure while frames remain
            r_secure <= !w_stk_empty;
         end
      end
   end

   // Sticky fault: a new fault beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault      <= 1'b0;
         r_fault_code <= OC8051_ECALL_F_NONE;
      end else if (w_fault_set) begin
         r_fault      <= 1'b1;
         r_fault_code <= w_fault_code;
      end else if (fault_clr) begin
         r_fault      <= 1'b0;
         r_fault_code <= OC8051_ECALL_F_NONE;
      end
   end

   assign stall      = (r_state != ST_IDLE);
   assign pc_wr      = (r_state == ST_E_JUMP) || (r_state == ST_R_JUMP);
   assign pc_target  = r_target;
   assign secure     = r_secure;
   assign fault      = r_fault;
   assign fault_code = r_fault_code;

endmodule : oc8051_ecall_unit
`default_nettype wire

// File: tb/tb_oc8051_ecall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_oc8051_ecall_unit
// Description : Scoreboard bench for the secure-call sequencer. A queue-based
//               return-stack model predicts every PC redirect and fault; a
//               monitor compares each pc_wr against the expected target queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oc8051_ecall_unit;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        ecall_req;
   logic        eret_req;
   logic [15:0] pc;
   logic [15:0] etr;
   logic        fault_clr;
   logic        stall;
   logic        pc_wr;
   logic [15:0] pc_target;
   logic        secure;
   logic [2:0]  depth;
   logic        fault;
   logic [1:0]  fault_code;

   int checks;
   int failures;

   // Reference model state
   logic [15:0] m_stack [$];
   logic [15:0] exp_q   [$];
   logic        m_fault;
   logic [1:0]  m_code;

   oc8051_ecall_unit #(
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ecall_req  (ecall_req),
      .eret_req   (eret_req),
      .pc         (pc),
      .etr        (etr),
      .fault_clr  (fault_clr),
      .stall      (stall),
      .pc_wr      (pc_wr),
      .pc_target  (pc_target),
      .secure     (secure),
      .depth      (depth),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every PC load must match the oldest predicted redirect
   always @(negedge clk) begin
      if (pc_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pc_wr: got target %h expected no pc_wr at %0t", pc_target, $time);
         end else begin
            chk("pc_target", {16'h0, pc_target}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // One request cycle followed by the full sequence window; model decides outcome
   task automatic issue(input bit ec, input bit er, input bit clr,
                        input logic [15:0] p, input logic [15:0] e,
                        input logic [15:0] e_after);
      bit         xfer;
      bit         newf;
      logic [1:0] code;
      xfer = 0;
      newf = 0;
      code = 2'b00;
      if (ec && er) begin
         newf = 1; code = 2'b11;
      end else if (ec) begin
         if (m_stack.size() == DEPTH) begin
            newf = 1; code = 2'b01;
         end else if (e == 16'h0000) begin
            newf = 1; code = 2'b11;
         end else begin
            m_stack.push_back(p);
            exp_q.push_back(e);
            xfer = 1;
         end
      end else if (er) begin
         if (m_stack.size() == 0) begin
            newf = 1; code = 2'b10;
         end else begin
            exp_q.push_back(m_stack.pop_back());
            xfer = 1;
         end
      end
      if (newf) begin
         m_fault = 1; m_code = code;
      end else if (clr) begin
         m_fault = 0; m_code = 2'b00;
      end
      ecall_req = ec;
      eret_req  = er;
      fault_clr = clr;
      pc        = p;
      etr       = e;
      @(posedge clk);
      #1;
      ecall_req = 0;
      eret_req  = 0;
      fault_clr = 0;
      etr       = e_after;
      @(negedge clk);
      chk("stall_n1", {31'h0, stall}, {31'h0, xfer});
      chk("fault", {31'h0, fault}, {31'h0, m_fault});
      chk("fault_code", {30'h0, fault_code}, {30'h0, m_code});
      @(negedge clk);
      chk("stall_n2", {31'h0, stall}, {31'h0, xfer});
      chk("pc_wr_n2", {31'h0, pc_wr}, {31'h0, xfer});
      @(negedge clk);
      chk("stall_n3", {31'h0, stall}, 32'h0);
      chk("depth", {29'h0, depth}, m_stack.size());
      chk("secure", {31'h0, secure}, {31'h0, (m_stack.size() != 0)});
   endtask

   // Reset driven into the middle of an accepted ECALL (during E_PUSH)
   task automatic reset_mid_sequence(input logic [15:0] p, input logic [15:0] e);
      ecall_req = 1;
      pc        = p;
      etr       = e;
      @(posedge clk);
      #1;
      ecall_req = 0;
      rst       = 1;
      m_stack.delete();
      m_fault = 0;
      m_code  = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_pc_wr", {31'h0, pc_wr}, 32'h0);
      chk("rst_depth", {29'h0, depth}, 32'h0);
      chk("rst_secure", {31'h0, secure}, 32'h0);
      @(negedge clk);
      chk("rst_pc_wr_late", {31'h0, pc_wr}, 32'h0);
   endtask

   initial begin
      logic [15:0] rp;
      logic [15:0] re;
      int          r;
      checks    = 0;
      failures  = 0;
      clk       = 0;
      rst       = 1;
      ecall_req = 0;
      eret_req  = 0;
      fault_clr = 0;
      pc        = 16'h0;
      etr       = 16'h0;
      m_fault   = 0;
      m_code    = 2'b00;
      repeat (3) @(negedge clk);
      chk("reset_stall", {31'h0, stall}, 32'h0);
      chk("reset_pc_wr", {31'h0, pc_wr}, 32'h0);
      chk("reset_pc_target", {16'h0, pc_target}, 32'h0);
      chk("reset_secure", {31'h0, secure}, 32'h0);
      chk("reset_depth", {29'h0, depth}, 32'h0);
      chk("reset_fault", {29'h0, fault, fault_code}, 32'h0);
      rst = 0;
      @(negedge clk);

      // Basic entry with ETR rewritten mid-sequence, then return
      issue(1, 0, 0, 16'h0123, 16'h8000, 16'h9000);
      issue(0, 1, 0, 16'h0000, 16'h9000, 16'h9000);

      // Nest to full, overflow, unwind
      for (int i = 1; i <= 4; i++) issue(1, 0, 0, 16'(i * 16), 16'h8000 + 16'(i), 16'h8000);
      issue(1, 0, 0, 16'h0050, 16'h8005, 16'h8005);
      for (int i = 0; i < 4; i++) issue(0, 1, 0, 16'h0, 16'h8000, 16'h8000);

      // Underflow, clear, no-target, simultaneous, clear-vs-new-fault
      issue(0, 1, 0, 16'h0, 16'h8000, 16'h8000);
      issue(0, 0, 1, 16'h0, 16'h8000, 16'h8000);
      issue(1, 0, 0, 16'h0200, 16'h0000, 16'h0000);
      issue(1, 0, 0, 16'h0300, 16'h8100, 16'h8100);
      issue(1, 1, 0, 16'h0400, 16'h8200, 16'h8200);
      issue(0, 1, 1, 16'h0, 16'h8200, 16'h8200);
      issue(0, 0, 1, 16'h0, 16'h8200, 16'h8200);
      issue(0, 1, 1, 16'h0, 16'h8200, 16'h8200);

      reset_mid_sequence(16'h0555, 16'h8000);

      // Randomized mix of requests and clears
      for (int i = 0; i < 200; i++) begin
         r  = $urandom_range(0, 99);
         rp = 16'($urandom);
         re = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
         issue(r < 50, (r >= 45) && (r < 95), $urandom_range(0, 9) == 0,
               rp, re, 16'($urandom));
      end

      repeat (3) @(negedge clk);
      chk("exp_queue_drained", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_oc8051_ecall_unit
`default_nettype wire
